// File: rtl/hazard_control_unit.sv
// Load-use / memory-wait / branch-flush hazard controller for the pipelined core.
// Control outputs are combinational from state and inputs; stall_count is registered.
module hazard_control_unit #(
  parameter int unsigned REG_W            = 5,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rs1,
  input  logic [REG_W-1:0] if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic             ex_mem_memread,
  input  logic             ex_mem_memwrite,
  input  logic             dmem_ready,
  input  logic             ex_branch_taken,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             control_mux_sel,
  output logic             if_id_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned REM_W = 3;
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_USE_BUBBLES - 1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t           state, next_state;
  logic [REM_W-1:0] remain, remain_n;
  logic             hazard;
  logic             mem_wait;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard = id_ex_memread && (id_ex_rd != '0) &&
                  ((if_id_use_rs1 && (id_ex_rd == if_id_rs1)) ||
                   (if_id_use_rs2 && (id_ex_rd == if_id_rs2)));

  assign mem_wait = (ex_mem_memread || ex_mem_memwrite) && !dmem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      remain <= '0;
    end else begin
      state  <= next_state;
      remain <= remain_n;
    end
  end

  // Priority: memory freeze, then branch flush, then pending/new load-use stall
  always_comb begin
    next_state      = state;
    remain_n        = remain;
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    control_mux_sel = 1'b1;
    if_id_flush     = 1'b0;
    pipe_freeze     = 1'b0;
    if (mem_wait) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush     = 1'b1;
      control_mux_sel = 1'b0;
      next_state      = IDLE;
      remain_n        = '0;
    end else if (state == STALL) begin
      pc_write        = 1'b0;
      if_id_write     = 1'b0;
      control_mux_sel = 1'b0;
      if (remain == REM_W'(1)) begin
        next_state = IDLE;
        remain_n   = '0;
      end else begin
        remain_n = remain - REM_W'(1);
      end
    end else if (hazard) begin
      pc_write        = 1'b0;
      if_id_write     = 1'b0;
      control_mux_sel = 1'b0;
      if (LOAD_USE_BUBBLES > 1) begin
        next_state = STALL;
        remain_n   = REM_INIT;
      end
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (cnt_clear) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Parametrised hazard controller for the pipelined RISC-V core, sitting between the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register. It extends single-cycle load-use detection with four additions: a configurable number of load-use bubbles, a freeze while data memory is not ready, a flush on taken branch/jump, and a saturating stall-cycle counter. It contains a small state machine so that multi-cycle stalls survive the load advancing out of ID/EX.

## Interface
- REG_W, 5, register-address width
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..7)
- CNT_W, 16, stall-counter width
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- id_ex_memread  input  1  instruction in EX is a load
- id_ex_rd  input  REG_W  destination of instruction in EX
- if_id_rs1, if_id_rs2  input  REG_W  sources of instruction in ID
- if_id_use_rs1, if_id_use_rs2  input  1  ID instruction actually reads rs1/rs2
- ex_mem_memread, ex_mem_memwrite  input  1  memory access in MEM stage
- dmem_ready  input  1  data memory completes access this cycle
- ex_branch_taken  input  1  branch/jump in EX redirects PC
- cnt_clear  input  1  synchronous clear of stall_count
- pc_write  output  1  1 = PC updates
- if_id_write  output  1  1 = IF/ID register loads
- control_mux_sel  output  1  1 = pass ID controls, 0 = inject bubble into ID/EX
- if_id_flush  output  1  1 = zero IF/ID (squash fetched instruction)
- pipe_freeze  output  1  1 = hold ID/EX, EX/MEM, MEM/WB registers
- stall_count  output  CNT_W  cycles with pc_write = 0, saturating

## Operation
- Hazard match (comb): id_ex_memread & id_ex_rd != 0 & ((use_rs1 & rd == rs1) | (use_rs2 & rd == rs2)). x0 never matches.
- mem_wait (comb): (ex_mem_memread | ex_mem_memwrite) & !dmem_ready.
- States: IDLE, STALL (internal down-counter `remain`, width 3).
- Priority per cycle: mem_wait > ex_branch_taken > STALL/hazard > normal.
- mem_wait: pc_write = 0, if_id_write = 0, pipe_freeze = 1, control_mux_sel = 1, if_id_flush = 0. State and `remain` are held.
- ex_branch_taken (no mem_wait): pc_write = 1, if_id_write = 1, if_id_flush = 1, control_mux_sel = 0. State goes to IDLE and any pending STALL is aborted, because the dependent instruction is squashed.
- IDLE with hazard match: pc_write = 0, if_id_write = 0, control_mux_sel = 0. If LOAD_USE_BUBBLES > 1, go to STALL with remain = LOAD_USE_BUBBLES-1; otherwise stay in IDLE.
- STALL: same outputs as the hazard case, regardless of the current hazard inputs. Decrement remain; at remain == 1 return to IDLE.
- Normal: pc_write = 1, if_id_write = 1, control_mux_sel = 1, if_id_flush = 0, pipe_freeze = 0.
- stall_count: increments by 1 on each cycle with pc_write = 0 and saturates at all-ones. cnt_clear has priority over the increment.

## Timing
- Reset (async): state IDLE, remain 0, stall_count 0. With inputs idle, outputs are pc_write = 1, if_id_write = 1, control_mux_sel = 1, if_id_flush = 0, pipe_freeze = 0.
- Control outputs are combinational from state and inputs in the same cycle, with zero-cycle latency. stall_count is registered and reflects stalls up to the previous edge.
- A load-use hazard detected in cycle T produces exactly LOAD_USE_BUBBLES cycles of pc_write = 0 (T..T+N-1), plus any mem_wait cycles interleaved. Normal flow resumes at T+N.
- mem_wait arriving during STALL extends the stall by the freeze length and does not consume bubbles.
- Reset asserted mid-STALL returns the block to IDLE immediately, with outputs at normal values.
- Simultaneous hazard match and ex_branch_taken: the flush wins, no stall is entered, and nothing is counted.

## Test plan
- Reset, then idle inputs -> pc_write = 1, if_id_write = 1, control_mux_sel = 1, flush = 0, freeze = 0, stall_count = 0.
- LOAD_USE_BUBBLES = 1, load rd = 5, ID rs2 = 5 with use_rs2 = 1 -> one cycle of pc_write = 0 and control_mux_sel = 0, stall_count = 1. Repeat with rd = 0 -> no stall.
- LOAD_USE_BUBBLES = 3, hazard at T, hazard inputs deasserted at T+1 -> stall persists for T, T+1 and T+2, normal at T+3, stall_count = 3.
- LOAD_USE_BUBBLES = 3, dmem_ready held low for 2 cycles at T+1 -> pc_write = 0 for 5 cycles, pipe_freeze = 1 for exactly 2 of them, stall_count = 5.
- Hazard and ex_branch_taken in the same cycle; and separately ex_branch_taken at T+1 of a 3-bubble stall -> if_id_flush = 1, control_mux_sel = 0, pc_write = 1, and IDLE on the next cycle.
- CNT_W = 3, 10 stall cycles -> stall_count saturates at 7. Assert cnt_clear -> 0. Reset asserted mid-STALL -> outputs at normal values immediately.
